// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: instruction-bus request and
// response, the F/D pipeline record handed to decode, and the fetch FSM
// state encoding.
package fetch_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        stall;
    } fetch_data_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Record presented to decode when no valid instruction is available
    localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'h0000_0000,
                                             pc:        64'h0000_0000_0000_0000,
                                             stall:     1'b1};

    // Sequential next-PC; wraps modulo 2^64, no alignment check
    function automatic logic [63:0] pc_inc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage with the F/D pipeline register.
// Owns the PC, issues instruction reads on ibus and hands one instruction per
// accepted cycle to decode. A redirect that arrives while a read is still in
// flight is remembered in a pending-target register and the stale response is
// dropped when it finally returns.
// Optional build macro: FETCH_PERF_EN adds perf_fetch / perf_bubble counters.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetch,
    output logic [63:0] perf_bubble
`endif
);

    // Architectural state
    fetch_state_t r_state;
    logic [63:0]  r_pc;
    logic         r_req_valid;
    logic         r_discard;
    logic [63:0]  r_pend_pc;
    logic [31:0]  r_hold_instr;
    logic [63:0]  r_hold_pc;
    fetch_data_t  r_data;

    // Next-state values
    fetch_state_t w_state_next;
    logic [63:0]  w_pc_next;
    logic         w_discard_next;
    logic [63:0]  w_pend_pc_next;
    logic [31:0]  w_hold_instr_next;
    logic [63:0]  w_hold_pc_next;
    fetch_data_t  w_data_next;

    // Qualified events for this cycle
    logic w_redirect;
    logic w_resp_ok;
    logic w_fresh_ok;
    logic w_unused;

    assign w_redirect = redirect_valid & ~stall_i;
    assign w_resp_ok  = r_req_valid & iresp.data_ok;
    assign w_fresh_ok = w_resp_ok & ~r_discard;
    // addr_ok and the upper data half carry no information for this stage
    assign w_unused   = ^{iresp.addr_ok, iresp.data[63:32]};

    assign ireq.valid = r_req_valid;
    assign ireq.addr  = r_pc;
    assign dataF      = r_data;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: park in HOLD only when a fresh response meets a stalled decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (w_fresh_ok && stall_i) begin
                    w_state_next = HOLD;
                end else begin
                    w_state_next = FETCH;
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    w_state_next = FETCH;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    // FSM outputs: next PC, discard/pending target, hold buffer and F/D record
    always_comb begin
        w_pc_next         = r_pc;
        w_discard_next    = r_discard;
        w_pend_pc_next    = r_pend_pc;
        w_hold_instr_next = r_hold_instr;
        w_hold_pc_next    = r_hold_pc;
        w_data_next       = r_data;
        case (r_state)
            FETCH: begin
                if (w_redirect) begin
                    // Current dataF is the redirecting instruction; it is consumed now
                    w_data_next = FETCH_BUBBLE;
                    if (r_req_valid && !iresp.data_ok) begin
                        // Keep the bus address stable; retarget once the read returns
                        w_discard_next = 1'b1;
                        w_pend_pc_next = redirect_pc;
                    end else begin
                        // Nothing outstanding (or it returns now and is dropped)
                        w_discard_next = 1'b0;
                        w_pc_next      = redirect_pc;
                    end
                end else if (w_resp_ok && r_discard) begin
                    // Stale response of a redirected read
                    w_discard_next = 1'b0;
                    w_pc_next      = r_pend_pc;
                    if (!stall_i) begin
                        w_data_next = FETCH_BUBBLE;
                    end else begin
                        w_data_next = r_data;
                    end
                end else if (w_resp_ok) begin
                    if (!stall_i) begin
                        w_data_next = '{raw_instr: iresp.data[31:0], pc: r_pc, stall: 1'b0};
                        w_pc_next   = pc_inc(r_pc);
                    end else begin
                        w_hold_instr_next = iresp.data[31:0];
                        w_hold_pc_next    = r_pc;
                    end
                end else begin
                    if (!stall_i) begin
                        w_data_next = FETCH_BUBBLE;
                    end else begin
                        w_data_next = r_data;
                    end
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    // Held instruction is on the wrong path
                    w_data_next = FETCH_BUBBLE;
                    w_pc_next   = redirect_pc;
                end else if (!stall_i) begin
                    w_data_next = '{raw_instr: r_hold_instr, pc: r_hold_pc, stall: 1'b0};
                    w_pc_next   = pc_inc(r_pc);
                end else begin
                    w_data_next = r_data;
                end
            end
            default: begin
                w_data_next = FETCH_BUBBLE;
            end
        endcase
    end

    // Datapath registers; a fresh request is presented whenever the FSM is in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_req_valid  <= 1'b0;
            r_discard    <= 1'b0;
            r_pend_pc    <= 64'h0000_0000_0000_0000;
            r_hold_instr <= 32'h0000_0000;
            r_hold_pc    <= 64'h0000_0000_0000_0000;
            r_data       <= FETCH_BUBBLE;
        end else begin
            r_pc         <= w_pc_next;
            r_req_valid  <= (w_state_next == FETCH);
            r_discard    <= w_discard_next;
            r_pend_pc    <= w_pend_pc_next;
            r_hold_instr <= w_hold_instr_next;
            r_hold_pc    <= w_hold_pc_next;
            r_data       <= w_data_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [63:0] r_perf_fetch;
    logic [63:0] r_perf_bubble;

    assign perf_fetch  = r_perf_fetch;
    assign perf_bubble = r_perf_bubble;

    // Count what decode actually accepts each unstalled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetch  <= 64'h0000_0000_0000_0000;
            r_perf_bubble <= 64'h0000_0000_0000_0000;
        end else if (!stall_i) begin
            if (r_data.stall) begin
                r_perf_bubble <= r_perf_bubble + 64'd1;
            end else begin
                r_perf_fetch  <= r_perf_fetch + 64'd1;
            end
        end else begin
            r_perf_fetch  <= r_perf_fetch;
            r_perf_bubble <= r_perf_bubble;
        end
    end
`endif

endmodule
